// File: rtl/zktc_gpio_ctrl.sv
// GPIO controller: bus-mapped OUT/DIR/IN/IRQ_EN/IRQ_STAT registers, synchronised
// inputs with rising-edge interrupt capture and a registered one-cycle bus ack.
module zktc_gpio_ctrl #(
  parameter int WIDTH       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [2:0]        addr_i,
  input  logic [15:0]       wdata_i,
  output logic [15:0]       rdata_o,
  output logic              ack_o,
  input  logic [WIDTH-1:0]  gpio_in,
  output logic [WIDTH-1:0]  gpio_out,
  output logic [WIDTH-1:0]  gpio_oe,
  output logic              irq_o
);

  localparam logic [2:0] ADDR_OUT  = 3'd0;
  localparam logic [2:0] ADDR_DIR  = 3'd1;
  localparam logic [2:0] ADDR_IN   = 3'd2;
  localparam logic [2:0] ADDR_IEN  = 3'd3;
  localparam logic [2:0] ADDR_STAT = 3'd4;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] ien_q, ien_d;
  logic [WIDTH-1:0] stat_q, stat_d;
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] prev_q;
  logic [15:0]      rdata_q, rdata_d;
  logic             ack_q, ack_d;

  logic [WIDTH-1:0] sync_last;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;
  logic [15:0]      rd_val;
  logic             wr;
  logic             unused_wdata;

  assign sync_last    = sync_q[SYNC_STAGES-1];
  assign rise         = sync_last & ~prev_q;
  assign wr           = req_i & we_i;
  assign unused_wdata = ^wdata_i;

  always_comb begin
    out_d  = out_q;
    dir_d  = dir_q;
    ien_d  = ien_q;
    clr    = '0;
    rd_val = '0;
    case (addr_i)
      ADDR_OUT: begin
        rd_val[WIDTH-1:0] = out_q;
        if (wr) out_d = wdata_i[WIDTH-1:0];
      end
      ADDR_DIR: begin
        rd_val[WIDTH-1:0] = dir_q;
        if (wr) dir_d = wdata_i[WIDTH-1:0];
      end
      ADDR_IN: begin
        rd_val[WIDTH-1:0] = sync_last;
      end
      ADDR_IEN: begin
        rd_val[WIDTH-1:0] = ien_q;
        if (wr) ien_d = wdata_i[WIDTH-1:0];
      end
      ADDR_STAT: begin
        rd_val[WIDTH-1:0] = stat_q;
        if (wr) clr = wdata_i[WIDTH-1:0];
      end
      default: ;
    endcase
    // A new edge wins over a same-cycle W1C so no event is lost.
    stat_d  = (stat_q & ~clr) | rise;
    rdata_d = (req_i && !we_i) ? rd_val : 16'h0000;
    ack_d   = req_i;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_q   <= '0;
      dir_q   <= '0;
      ien_q   <= '0;
      stat_q  <= '0;
      prev_q  <= '0;
      rdata_q <= '0;
      ack_q   <= 1'b0;
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      out_q   <= out_d;
      dir_q   <= dir_d;
      ien_q   <= ien_d;
      stat_q  <= stat_d;
      prev_q  <= sync_last;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      sync_q[0] <= gpio_in;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign gpio_out = out_q;
  assign gpio_oe  = dir_q;
  assign irq_o    = |(stat_q & ien_q);
  assign rdata_o  = rdata_q;
  assign ack_o    = ack_q;

endmodule

// File: tb/tb_zktc_gpio_ctrl.sv
// Directed bench for zktc_gpio_ctrl (WIDTH=8, SYNC_STAGES=2); inputs driven and
// outputs sampled on the falling clock edge.
module tb_zktc_gpio_ctrl;

  logic        clk;
  logic        rstn;
  logic        req_i;
  logic        we_i;
  logic [2:0]  addr_i;
  logic [15:0] wdata_i;
  logic [15:0] rdata_o;
  logic        ack_o;
  logic [7:0]  gpio_in;
  logic [7:0]  gpio_out;
  logic [7:0]  gpio_oe;
  logic        irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  zktc_gpio_ctrl #(.WIDTH(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_i    (req_i),
    .we_i     (we_i),
    .addr_i   (addr_i),
    .wdata_i  (wdata_i),
    .rdata_o  (rdata_o),
    .ack_o    (ack_o),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .gpio_oe  (gpio_oe),
    .irq_o    (irq_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, want 0x%04h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; the request is sampled by the next rising edge
  // and the ack/rdata are captured at the falling edge after it.
  task automatic bus(input logic we, input logic [2:0] addr, input logic [15:0] wd,
                     output logic [15:0] rd, output logic ack);
    req_i   = 1'b1;
    we_i    = we;
    addr_i  = addr;
    wdata_i = wd;
    @(negedge clk);
    rd      = rdata_o;
    ack     = ack_o;
    req_i   = 1'b0;
    we_i    = 1'b0;
    wdata_i = 16'h0000;
  endtask

  task automatic rd_chk(input string tag, input logic [2:0] addr, input logic [15:0] exp);
    logic [15:0] rd;
    logic        ack;
    bus(1'b0, addr, 16'h0000, rd, ack);
    chk({tag, "_ack"}, {15'd0, ack}, 16'h0001);
    chk(tag, rd, exp);
  endtask

  task automatic wr_chk(input string tag, input logic [2:0] addr, input logic [15:0] wd);
    logic [15:0] rd;
    logic        ack;
    bus(1'b1, addr, wd, rd, ack);
    chk({tag, "_ack"}, {15'd0, ack}, 16'h0001);
    chk({tag, "_rdata"}, rd, 16'h0000);
  endtask

  initial begin
    rstn    = 1'b0;
    req_i   = 1'b0;
    we_i    = 1'b0;
    addr_i  = 3'd0;
    wdata_i = 16'h0000;
    gpio_in = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_out",   {8'h00, gpio_out}, 16'h0000);
    chk("rst_oe",    {8'h00, gpio_oe},  16'h0000);
    chk("rst_irq",   {15'd0, irq_o},    16'h0000);
    chk("rst_ack",   {15'd0, ack_o},    16'h0000);
    chk("rst_rdata", rdata_o,           16'h0000);
    rstn = 1'b1;
    @(negedge clk);
    chk("rel_out",   {8'h00, gpio_out}, 16'h0000);
    chk("rel_ack",   {15'd0, ack_o},    16'h0000);
    chk("rel_rdata", rdata_o,           16'h0000);
    for (int a = 0; a < 5; a++) rd_chk("rst_read", 3'(a), 16'h0000);

    // OUT / DIR
    wr_chk("wr_dir", 3'd1, 16'h00F0);
    wr_chk("wr_out", 3'd0, 16'hFFA5);
    chk("oe",  {8'h00, gpio_oe},  16'h00F0);
    chk("out", {8'h00, gpio_out}, 16'h00A5);
    rd_chk("rd_out", 3'd0, 16'h00A5);
    @(negedge clk);
    chk("ack_single", {15'd0, ack_o}, 16'h0000);
    chk("rdata_idle", rdata_o, 16'h0000);

    // IN is read-only; unmapped writes ignored
    wr_chk("wr_in", 3'd2, 16'h00FF);
    rd_chk("rd_in_ro", 3'd2, 16'h0000);
    wr_chk("wr_7", 3'd7, 16'hFFFF);
    chk("out_unmapped", {8'h00, gpio_out}, 16'h00A5);
    chk("oe_unmapped",  {8'h00, gpio_oe},  16'h00F0);

    // Input sync: pin changes before edge N; reads below sample at N..N+3
    gpio_in = 8'h02;
    rd_chk("in_N",     3'd2, 16'h0000);
    rd_chk("in_N1",    3'd2, 16'h0000);
    rd_chk("in_N2",    3'd2, 16'h0002);
    rd_chk("stat_N3",  3'd4, 16'h0002);
    chk("irq_masked", {15'd0, irq_o}, 16'h0000);

    // Interrupt enable and W1C
    wr_chk("wr_ien", 3'd3, 16'h0002);
    chk("irq_on", {15'd0, irq_o}, 16'h0001);
    wr_chk("w1c_zero", 3'd4, 16'h0001);
    chk("irq_w1c0", {15'd0, irq_o}, 16'h0001);
    rd_chk("stat_w1c0", 3'd4, 16'h0002);
    wr_chk("w1c", 3'd4, 16'h0002);
    chk("irq_off", {15'd0, irq_o}, 16'h0000);
    rd_chk("stat_clr", 3'd4, 16'h0000);

    // Collision: new edge's set lands on the same edge as a W1C of bit1
    gpio_in = 8'h00;
    repeat (4) @(negedge clk);
    gpio_in = 8'h02;
    @(negedge clk);
    @(negedge clk);
    chk("irq_pre_coll", {15'd0, irq_o}, 16'h0000);
    wr_chk("w1c_coll", 3'd4, 16'h0002);
    chk("irq_coll", {15'd0, irq_o}, 16'h0001);
    rd_chk("stat_coll", 3'd4, 16'h0002);

    // Bus edge cases
    rd_chk("rd_6", 3'd6, 16'h0000);
    rd_chk("b2b_0", 3'd0, 16'h00A5);
    rd_chk("b2b_1", 3'd1, 16'h00F0);

    // Reset while an access is outstanding; pin 1 stays high through reset
    req_i  = 1'b1;
    we_i   = 1'b0;
    addr_i = 3'd0;
    @(posedge clk);
    #1;
    rstn  = 1'b0;
    req_i = 1'b0;
    #1;
    chk("rst_ack_cancel", {15'd0, ack_o}, 16'h0000);
    chk("rst_rdata_clr",  rdata_o, 16'h0000);
    chk("rst_irq2",       {15'd0, irq_o}, 16'h0000);
    chk("rst_out2",       {8'h00, gpio_out}, 16'h0000);
    @(negedge clk);
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ack", {15'd0, ack_o}, 16'h0000);
    rd_chk("stat_R2", 3'd4, 16'h0000);
    rd_chk("stat_R3", 3'd4, 16'h0000);
    rd_chk("stat_R4", 3'd4, 16'h0002);
    rd_chk("in_post", 3'd2, 16'h0002);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/zktc_gpio_ctrl.md
ZKTC_GPIO_CTRL -- requirements
Module: zktc_gpio_ctrl

Interface
REQ-001 SHALL provide parameter WIDTH, default 8, number of GPIO pins (1..16).
REQ-002 SHALL provide parameter SYNC_STAGES, default 2, input synchronizer depth (>=2).
REQ-003 SHALL have one clock and an asynchronous, active-low reset.
REQ-004 SHALL have port clk  input  1  system clock, all state on rising edge.
REQ-005 SHALL have port rstn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req_i  input  1  bus access request, one cycle per access.
REQ-007 SHALL have port we_i  input  1  1 = write, 0 = read, qualified by req_i.
REQ-008 SHALL have port addr_i  input  3  register word address.
REQ-009 SHALL have port wdata_i  input  16  write data.
REQ-010 SHALL have port rdata_o  output  16  read data, valid with ack_o.
REQ-011 SHALL have port ack_o  output  1  access-complete pulse.
REQ-012 SHALL have port gpio_in  input  WIDTH  asynchronous pin input values.
REQ-013 SHALL have port gpio_out  output  WIDTH  pin drive values.
REQ-014 SHALL have port gpio_oe  output  WIDTH  per-pin output enable, 1 = drive.
REQ-015 SHALL have port irq_o  output  1  level interrupt to CPU.

Function
REQ-016 SHALL decode the register map: 0 OUT (RW), 1 DIR (RW), 2 IN (RO), 3 IRQ_EN (RW), 4 IRQ_STAT (W1C); addresses 5-7 unmapped.
REQ-017 SHALL assert ack_o for exactly one cycle, on the cycle after each cycle in which req_i = 1, including accesses to unmapped addresses.
REQ-018 SHALL present rdata_o in the ack cycle for reads, and drive rdata_o = 0 in all other cycles and for writes.
REQ-019 SHALL use wdata_i[WIDTH-1:0] on writes, ignore the upper bits, and read upper bits as 0.
REQ-020 SHALL commit a write on the clock edge at which req_i & we_i is sampled.
REQ-021 SHALL read as 0 at unmapped addresses, and SHALL ignore writes to unmapped addresses and to IN.
REQ-022 SHALL drive gpio_out = OUT and gpio_oe = DIR directly from the registers (no combinational path from the bus).
REQ-023 SHALL pass each gpio_in bit through a SYNC_STAGES-flop chain; IN returns the last stage.
REQ-024 SHALL register the last sync stage into a previous-value flop; rising edge = sync_last & ~prev.
REQ-025 SHALL set the IRQ_STAT bit on the edge after a rising edge is detected. With SYNC_STAGES = 2, an input sampled high at edge N reads in IN after edge N+1 and sets IRQ_STAT at edge N+2.
REQ-026 SHALL detect rising edges regardless of DIR or IRQ_EN; IRQ_EN gates only irq_o.
REQ-027 SHALL clear each IRQ_STAT bit written with 1; bits written with 0 are unchanged.
REQ-028 SHALL give set priority when a set and a W1C clear hit the same bit in the same cycle: the bit stays 1.
REQ-029 SHALL drive irq_o = |(IRQ_STAT & IRQ_EN), registered-source, updating in the same cycle as either register.
REQ-030 SHALL accept back-to-back requests on consecutive cycles, each acked one cycle later.

Reset
REQ-031 SHALL asynchronously clear OUT, DIR, IRQ_EN, IRQ_STAT, the sync chain, prev, ack_o and rdata_o on rstn = 0; gpio_out = 0, gpio_oe = 0, irq_o = 0.
REQ-032 SHALL cancel any in-flight access on reset: no ack_o after rstn deasserts for a request sampled before reset.
REQ-033 SHALL treat a pin held high through reset release as a rising edge: its IRQ_STAT bit sets SYNC_STAGES+1 cycles after release.

Verification
REQ-034 SHALL cover reset: all outputs 0 during rstn = 0 and on the first cycle after release; reading addr 0-4 returns 0x0000 except IN/IRQ_STAT per held inputs.
REQ-035 SHALL cover OUT/DIR: write addr1 = 0x00F0, addr0 = 0xFFA5 -> gpio_oe = 0xF0, gpio_out = 0xA5; read addr0 returns 0x00A5 with ack one cycle after req.
REQ-036 SHALL cover input sync: gpio_in steps 0x00 -> 0x02 at edge N -> IN reads 0x02 from edge N+2; IRQ_STAT bit1 set at N+2; irq_o stays 0 while IRQ_EN = 0.
REQ-037 SHALL cover interrupt: IRQ_EN = 0x02, IRQ_STAT bit1 set -> irq_o = 1; write addr4 = 0x0002 -> irq_o = 0 the next cycle.
REQ-038 SHALL cover collision: a new rising edge on bit1 coincides with a W1C of bit1 -> IRQ_STAT bit1 stays 1 and irq_o stays 1.
REQ-039 SHALL cover the bus and reset edge cases: a read of addr6 returns 0 with ack; back-to-back reads of addr0 and addr1 ack on consecutive cycles; rstn pulsed low during an outstanding req -> no ack.
